// File: rtl/rhythm_score_engine.sv
// rhythm_score_engine: per-lane hit grading feeding a two-stage combo / saturating-score pipeline.
// Build option HISCORE_EN adds a best-final-score register on o_hi_score (tied to 0 otherwise).

module rhythm_score_lane #(
    parameter int PTS_W       = 4,
    parameter int PTS_GOOD    = 2,
    parameter int PTS_PERFECT = 4
) (
    input  logic [1:0]       i_grade,
    output logic [PTS_W-1:0] o_pts,
    output logic             o_hit,
    output logic             o_miss
);
    always_comb begin
        o_pts  = '0;
        o_hit  = 1'b0;
        o_miss = 1'b0;
        case (i_grade)
            2'b01: o_miss = 1'b1;
            2'b10: begin
                o_pts = PTS_W'(PTS_GOOD);
                o_hit = 1'b1;
            end
            2'b11: begin
                o_pts = PTS_W'(PTS_PERFECT);
                o_hit = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module rhythm_score_engine #(
    parameter int LANES       = 2,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int MULT_STEP   = 16,
    parameter int MULT_MAX    = 17,
    parameter int PTS_GOOD    = 2,
    parameter int PTS_PERFECT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_game_state,
    input  logic                 i_hit_valid,
    input  logic [2*LANES-1:0]   i_hit_grade,
    output logic [SCORE_W-1:0]   o_score,
    output logic [COMBO_W-1:0]   o_combo,
    output logic [COMBO_W-1:0]   o_max_combo,
    output logic [4:0]           o_multiplier,
    output logic                 o_score_valid,
    output logic                 o_saturated,
    output logic [SCORE_W-1:0]   o_hi_score
);
    localparam int PTS_W  = $clog2(LANES*PTS_PERFECT+1);
    localparam int NHIT_W = $clog2(LANES+1);
    localparam int MULT_W = 5;
    localparam int ADD_W  = PTS_W + MULT_W;
    localparam int SUM_W  = ((SCORE_W > ADD_W) ? SCORE_W : ADD_W) + 1;
    localparam int CSUM_W = COMBO_W + NHIT_W;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_SELECT = 2'd1,
        GS_PLAY   = 2'd2,
        GS_OVER   = 2'd3
    } game_state_e;

    logic [LANES-1:0][PTS_W-1:0] w_lane_pts;
    logic [LANES-1:0]            w_lane_hit;
    logic [LANES-1:0]            w_lane_miss;
    logic [PTS_W-1:0]            w_pts;
    logic [NHIT_W-1:0]           w_nhit;
    logic                        w_miss;

    logic                        w_accept;
    logic                        w_apply;
    logic                        w_clear;

    // [0]: stage-1 event held, [1]: event applied this cycle (score_valid)
    logic [1:0]                  r_vld_pipe;
    logic [PTS_W-1:0]            r_s1_pts;
    logic [NHIT_W-1:0]           r_s1_nhit;
    logic                        r_s1_miss;

    logic [SCORE_W-1:0]          r_score;
    logic [COMBO_W-1:0]          r_combo;
    logic [COMBO_W-1:0]          r_max_combo;
    logic                        r_saturated;

    logic [COMBO_W-1:0]          w_steps;
    logic [MULT_W-1:0]           w_mult;
    logic [ADD_W-1:0]            w_add;
    logic [SUM_W-1:0]            w_sum;
    logic                        w_clamp;
    logic [CSUM_W-1:0]           w_csum;
    logic [COMBO_W-1:0]          w_combo_nx;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rhythm_score_lane #(
            .PTS_W       (PTS_W),
            .PTS_GOOD    (PTS_GOOD),
            .PTS_PERFECT (PTS_PERFECT)
        ) u_lane (
            .i_grade (i_hit_grade[2*l +: 2]),
            .o_pts   (w_lane_pts[l]),
            .o_hit   (w_lane_hit[l]),
            .o_miss  (w_lane_miss[l])
        );
    end

    always_comb begin
        w_pts  = '0;
        w_nhit = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pts  = w_pts + w_lane_pts[l];
            w_nhit = w_nhit + NHIT_W'(w_lane_hit[l]);
        end
    end
    assign w_miss = |w_lane_miss;

    assign w_clear  = (i_game_state == GS_SELECT);
    assign w_accept = i_hit_valid && (i_game_state == GS_PLAY);
    assign w_apply  = r_vld_pipe[0] && (i_game_state == GS_PLAY);

    // Multiplier tracks the combo before the pending event is applied
    assign w_steps = (r_combo - COMBO_W'(1)) / COMBO_W'(MULT_STEP);
    always_comb begin
        if (r_combo == '0)
            w_mult = MULT_W'(1);
        else if (w_steps >= COMBO_W'(MULT_MAX-2))
            w_mult = MULT_W'(MULT_MAX);
        else
            w_mult = MULT_W'(w_steps) + MULT_W'(2);
    end

    assign w_add   = ADD_W'(r_s1_pts) * ADD_W'(w_mult);
    assign w_sum   = SUM_W'(r_score) + SUM_W'(w_add);
    assign w_clamp = |w_sum[SUM_W-1:SCORE_W];

    // A miss anywhere in the event breaks the combo even if other lanes hit
    assign w_csum = CSUM_W'(r_combo) + CSUM_W'(r_s1_nhit);
    always_comb begin
        if (r_s1_miss)
            w_combo_nx = '0;
        else if (|w_csum[CSUM_W-1:COMBO_W])
            w_combo_nx = '1;
        else
            w_combo_nx = w_csum[COMBO_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_s1_pts    <= '0;
            r_s1_nhit   <= '0;
            r_s1_miss   <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_saturated <= 1'b0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            if (w_accept) begin
                r_s1_pts  <= w_pts;
                r_s1_nhit <= w_nhit;
                r_s1_miss <= w_miss;
            end

            if (w_clear) begin
                r_score       <= '0;
                r_combo       <= '0;
                r_max_combo   <= '0;
                r_saturated   <= 1'b0;
                r_vld_pipe[1] <= 1'b0;
            end else if (w_apply) begin
                r_score       <= w_clamp ? '1 : w_sum[SCORE_W-1:0];
                r_saturated   <= r_saturated | w_clamp;
                r_combo       <= w_combo_nx;
                if (w_combo_nx > r_max_combo)
                    r_max_combo <= w_combo_nx;
                r_vld_pipe[1] <= 1'b1;
            end else begin
                r_vld_pipe[1] <= 1'b0;
            end
        end
    end

`ifdef HISCORE_EN
    logic [1:0]         r_prev_state;
    logic [SCORE_W-1:0] r_hi_score;

    // Score is frozen once GAME_OVER is seen, so the current value is the final one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= GS_IDLE;
            r_hi_score   <= '0;
        end else begin
            r_prev_state <= i_game_state;
            if ((i_game_state == GS_OVER) && (r_prev_state == GS_PLAY) && (r_score > r_hi_score))
                r_hi_score <= r_score;
        end
    end
    assign o_hi_score = r_hi_score;
`else
    assign o_hi_score = '0;
`endif

    assign o_score       = r_score;
    assign o_combo       = r_combo;
    assign o_max_combo   = r_max_combo;
    assign o_multiplier  = w_mult;
    assign o_score_valid = r_vld_pipe[1];
    assign o_saturated   = r_saturated;
endmodule
